// File: rtl/bsg_bus_pkg.sv
// Shared types and constants for the BSG register-bus initiator.
// Holds the FSM state encoding, the queued command format and the register map.
package bsg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAPT = 3'd3,
        RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    localparam logic [7:0] BSG_CONTROL_ADDR = 8'h10;
    localparam logic [7:0] BSG_DATA1_ADDR   = 8'h11;
    localparam logic [7:0] BSG_DATA2_ADDR   = 8'h12;

endpackage

// File: rtl/bsg_cmd_fifo.sv
// Command FIFO for the bus initiator: power-of-two depth, full/empty flags, no bypass.
// A push while full is dropped even if a pop happens in the same cycle.
module bsg_cmd_fifo
    import bsg_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    cmd_t        r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    // NOTE: storage is not reset; empty pointers make stale entries unreadable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/bsg_bus_initiator.sv
// BSG register-bus initiator: queues commands, executes them one at a time, one response each.
// Define BSG_INIT_TIMEOUT_EN to compile in the write timeout (rsp_err); otherwise writes wait forever.
module bsg_bus_initiator
    import bsg_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_valid,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("bsg_bus_initiator: illegal FIFO_DEPTH or TIMEOUT");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    cmd_t       w_cmd_in;
    cmd_t       w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_tmo_hit;
    logic       w_wr_end;
    logic [7:0] r_bus_addr;
    logic [7:0] r_bus_wdata;
    logic [7:0] r_rsp_rdata;

    assign w_cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    bsg_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_wr_end = (r_state == WR_REQ) && (bus_ready || w_tmo_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head.write ? WR_REQ : RD_ADDR;
                end
            end
            WR_REQ:  if (w_wr_end) w_state_nxt = RESP;
            RD_ADDR: w_state_nxt = RD_CAPT;
            RD_CAPT: w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Active command: address always reloads, write data only for writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_pop) begin
            r_bus_addr <= w_head.addr;
            if (w_head.write) r_bus_wdata <= w_head.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_rsp_rdata <= '0;
        else if (w_wr_end)           r_rsp_rdata <= '0;
        else if (r_state == RD_CAPT) r_rsp_rdata <= bus_rdata;
    end

`ifdef BSG_INIT_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_rsp_err;

    // Times out on the TIMEOUT-th consecutive edge that sees bus_ready low.
    assign w_tmo_hit = (r_state == WR_REQ) && !bus_ready &&
                       (r_tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == RESP && rsp_ready)        r_tmo_cnt <= '0;
            else if (r_state == WR_REQ && !bus_ready) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (w_wr_end)                r_rsp_err <= w_tmo_hit;
            else if (r_state == RD_CAPT) r_rsp_err <= 1'b0;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_tmo_hit = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign cmd_ready = !w_full;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign bus_valid = (r_state == WR_REQ);
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_bsg_bus_initiator.sv
// Self-checking bench for bsg_bus_initiator: directed timing cases plus randomized traffic,
// scored against an in-order register-file model; adapts to BSG_INIT_TIMEOUT_EN.
module tb_bsg_bus_initiator;
    import bsg_bus_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;
`ifdef BSG_INIT_TIMEOUT_EN
    localparam int STALL = 5;
`else
    localparam int STALL = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_rdata;

    // Handshake inputs come either from directed stimulus or from the random driver.
    logic rdy_mode = 1'b0, rdy_force = 1'b1, rdy_rand = 1'b1;
    logic rsp_mode = 1'b0, rsp_force = 1'b1, rsp_rand = 1'b1;
    assign bus_ready = rdy_mode ? rdy_rand : rdy_force;
    assign rsp_ready = rsp_mode ? rsp_rand : rsp_force;

    bsg_bus_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] init_val(int i);
        if (i == int'(BSG_CONTROL_ADDR)) return 8'h81;
        if (i == int'(BSG_DATA1_ADDR))   return 8'h00;
        if (i == int'(BSG_DATA2_ADDR))   return 8'h3C;
        return 8'(i) ^ 8'h5A;
    endfunction

    // Responder: write on valid&ready, data_out registered one edge after the address.
    logic [7:0] resp_mem [256];
    initial for (int i = 0; i < 256; i++) resp_mem[i] <= init_val(i);
    always @(posedge clk) begin
        if (bus_valid && bus_ready) resp_mem[bus_addr] <= bus_wdata;
        bus_rdata <= resp_mem[bus_addr];
    end

    // Reference model: register contents as seen by commands in acceptance order.
    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] old;
        logic [7:0] rdata;
        logic       err;
        int         acc;
        int         lat;
    } exp_t;

    logic [7:0] ref_mem [256];
    exp_t       sb [$];
    int         total = 0;
    int         bad = 0;
    int         n_rsp = 0;
    logic       exp_err = 1'b0;
    int         chk_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Scoreboard push: every accepted command gets its expected response.
    initial begin : acc_proc
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                e.wr   = cmd_write;
                e.addr = cmd_addr;
                e.old  = ref_mem[cmd_addr];
                e.acc  = cycle;
                e.lat  = chk_lat;
                if (cmd_write) begin
                    e.rdata = 8'h00;
                    e.err   = exp_err;
                    if (!exp_err) ref_mem[cmd_addr] = cmd_wdata;
                end else begin
                    e.rdata = ref_mem[cmd_addr];
                    e.err   = 1'b0;
                end
                sb.push_back(e);
            end
        end
    end

    // Monitor: latency on first visibility, stability while stalled, compare on handshake.
    initial begin : mon_proc
        exp_t       h;
        logic       prev_v = 1'b0;
        logic       prev_r = 1'b0;
        logic [8:0] prev_f = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (prev_v && !prev_r)
                    check("rsp_stable", 32'({rsp_err, rsp_rdata}), 32'(prev_f));
                if (!prev_v && sb.size() != 0 && sb[0].lat != 0)
                    check("rsp_latency", cycle - sb[0].acc, sb[0].lat);
                if (rsp_ready) begin
                    check("rsp_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        h = sb.pop_front();
                        check("rsp_rdata", 32'(rsp_rdata), 32'(h.rdata));
                        check("rsp_err", 32'(rsp_err), 32'(h.err));
                        n_rsp++;
                    end
                end
            end
            prev_v = rsp_valid;
            prev_r = rsp_ready;
            prev_f = {rsp_err, rsp_rdata};
        end
    end

    // Random handshake driver; write stalls are capped well below TIMEOUT.
    initial begin : rnd_proc
        int stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_valid && stall >= 4) rdy_rand = 1'b1;
            else                         rdy_rand = 1'($urandom % 2);
            if (bus_valid && !rdy_rand) stall++;
            else                        stall = 0;
            rsp_rand = ($urandom % 4) != 0;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("issue_accepted", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin : stim
        int         bv;
        int         acc;
        int         n0;
        int         n;
        logic       will;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 0);
        check("reset_bus_valid", 32'(bus_valid), 0);
        check("reset_bus_addr", 32'(bus_addr), 0);
        check("reset_bus_wdata", 32'(bus_wdata), 0);

        // Single write with bus_ready high.
        rdy_force = 1'b1;
        chk_lat   = 3;
        issue(1'b1, BSG_DATA1_ADDR, 8'hA5);
        bv = 0;
        repeat (10) begin
            if (bus_valid) begin
                bv++;
                check("wr_bus_addr", 32'(bus_addr), 32'h11);
                check("wr_bus_wdata", 32'(bus_wdata), 32'hA5);
            end
            @(posedge clk);
            #1;
        end
        check("wr_valid_cycles", bv, 1);

        // Read of DATA2.
        chk_lat = 4;
        issue(1'b0, BSG_DATA2_ADDR, 8'hFF);
        bv = 0;
        repeat (10) begin
            if (bus_valid) bv++;
            @(posedge clk);
            #1;
        end
        check("rd_valid_cycles", bv, 0);

        // Write stalled by bus_ready low.
        chk_lat   = 3 + STALL;
        rdy_force = 1'b0;
        issue(1'b1, BSG_DATA1_ADDR, 8'h5C);
        bv = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus_valid) begin
                bv++;
                if (bv == STALL + 1) rdy_force = 1'b1;
            end
        end
        check("stall_valid_cycles", bv, STALL + 1);

        // bus_ready stuck low.
        chk_lat   = 0;
        rdy_force = 1'b0;
`ifdef BSG_INIT_TIMEOUT_EN
        exp_err = 1'b1;
        issue(1'b1, BSG_CONTROL_ADDR, 8'h77);
        exp_err = 1'b0;
        bv = 0;
        repeat (30) begin
            if (bus_valid) bv++;
            @(posedge clk);
            #1;
        end
        check("tmo_valid_cycles", bv, TMO);
        rdy_force = 1'b1;
`else
        issue(1'b1, BSG_CONTROL_ADDR, 8'h77);
        bv = 0;
        repeat (30) begin
            if (bus_valid) bv++;
            @(posedge clk);
            #1;
        end
        check("no_tmo_valid_cycles", bv, 29);
        rdy_force = 1'b1;
        repeat (6) @(posedge clk);
        #1;
`endif
        repeat (4) @(posedge clk);
        #1;
        check("directed_drained", sb.size(), 0);

        // Fill the FIFO while the response is held.
        rsp_force = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'(acc % 2 == 0);
            cmd_addr  = 8'h10 + 8'(acc % 3);
            cmd_wdata = 8'hC0 + 8'(acc);
            will = cmd_ready;
            @(posedge clk);
            #1;
            if (will) acc++;
        end
        cmd_valid = 1'b0;
        check("full_accepted", acc, DEPTH + 1);
        check("full_cmd_ready", 32'(cmd_ready), 0);
        n0 = n_rsp;
        rsp_force = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("full_responses", n_rsp - n0, DEPTH + 1);

        // Reset during WR_REQ.
        rdy_force = 1'b0;
        n0 = n_rsp;
        issue(1'b1, BSG_DATA2_ADDR, 8'hEE);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_bus_valid", 32'(bus_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_bus_valid", 32'(bus_valid), 0);
        check("rst_async_rsp_valid", 32'(rsp_valid), 0);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].wr && !sb[i].err) ref_mem[sb[i].addr] = sb[i].old;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        rdy_force = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_stale_rsp", n_rsp, n0);
        chk_lat = 4;
        issue(1'b0, BSG_DATA2_ADDR, 8'h00);
        repeat (8) @(posedge clk);
        #1;
        check("rst_readback", n_rsp, n0 + 1);

        // Randomized traffic.
        chk_lat  = 0;
        rdy_mode = 1'b1;
        rsp_mode = 1'b1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom % 2 != 0) a = 8'h10 + 8'($urandom % 3);
            else                   a = 8'($urandom);
            issue(1'($urandom % 2), a, 8'($urandom));
            repeat ($urandom % 3) begin
                @(posedge clk);
                #1;
            end
        end
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("random_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
